xoodoo_perm_driver_sca: RTL and testbench



---
 rtl/xoodoo_pkg.sv | 52 +++++
 rtl/xoodoo_prng_sca.sv | 32 +++
 rtl/xoodoo_round_dom.sv | 80 ++++++++
 rtl/xoodoo_perm_driver_sca.sv | 104 ++++++++++
 tb/tb_xoodoo_perm_driver_sca.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/xoodoo_pkg.sv
// Shared constants, state encoding and helper functions for the masked Xoodoo sequencer.
`default_nettype none

package xoodoo_pkg;

  localparam int          NROUNDS   = 12;
  localparam logic [3:0]  LAST_RND  = 4'(NROUNDS - 1);
  localparam logic [31:0] PRNG_INIT = 32'h9E3779B9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    CAPT = 2'd2,
    DONE = 2'd3
  } state_t;

  // Round-constant table; entries past the last round are zero.
  function automatic logic [31:0] rc_lookup(input logic [3:0] r);
    logic [31:0] v;
    case (r)
      4'd0:    v = 32'h058;
      4'd1:    v = 32'h038;
      4'd2:    v = 32'h3C0;
      4'd3:    v = 32'h0D0;
      4'd4:    v = 32'h120;
      4'd5:    v = 32'h014;
      4'd6:    v = 32'h060;
      4'd7:    v = 32'h02C;
      4'd8:    v = 32'h380;
      4'd9:    v = 32'h0F0;
      4'd10:   v = 32'h1A0;
      4'd11:   v = 32'h012;
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] v, input int unsigned n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] xorshift32(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

endpackage

`default_nettype wire

// File: rtl/xoodoo_prng_sca.sv
// Twelve independent 32-bit xorshift generators supplying the DOM refresh randomness.
`default_nettype none

module xoodoo_prng_sca
  import xoodoo_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         seed_we,
  input  logic [383:0] seed,
  output logic [383:0] rs
);

  logic [11:0][31:0] words;

  assign rs = words;

  // A zero word would lock its xorshift generator at zero forever.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 12; i++) words[i] <= PRNG_INIT ^ 32'(i);
    end else if (seed_we) begin
      for (int i = 0; i < 12; i++)
        words[i] <= (seed[32*i +: 32] == 32'h0) ? 32'h00000001 : seed[32*i +: 32];
    end else begin
      for (int i = 0; i < 12; i++) words[i] <= xorshift32(words[i]);
    end
  end

endmodule

`default_nettype wire

// File: rtl/xoodoo_round_dom.sv
// Registered single-round two-share Xoodoo core; chi uses DOM-independent AND gadgets.
`default_nettype none

module xoodoo_round_dom
  import xoodoo_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [383:0] in_0,
  input  logic [383:0] in_1,
  input  logic [31:0]  rconst,
  input  logic [383:0] rs,
  output logic [383:0] out_0,
  output logic [383:0] out_1
);

  // theta, rho-west and iota; all linear so each share is processed independently.
  function automatic logic [383:0] lin_pre(input logic [383:0] a, input logic [31:0] rcv);
    logic [11:0][31:0] w;
    logic [11:0][31:0] o;
    logic [3:0][31:0]  p;
    logic [3:0][31:0]  e;
    w = a;
    for (int x = 0; x < 4; x++) p[x] = w[x] ^ w[4+x] ^ w[8+x];
    for (int x = 0; x < 4; x++) e[x] = rotl(p[(x+3)%4], 5) ^ rotl(p[(x+3)%4], 14);
    for (int i = 0; i < 12; i++) w[i] = w[i] ^ e[i%4];
    for (int x = 0; x < 4; x++) begin
      o[x]   = w[x];
      o[4+x] = w[4+((x+3)%4)];
      o[8+x] = rotl(w[8+x], 11);
    end
    o[0] = o[0] ^ rcv;
    return o;
  endfunction

  function automatic logic [383:0] lin_post(input logic [383:0] a);
    logic [11:0][31:0] w;
    logic [11:0][31:0] o;
    w = a;
    for (int x = 0; x < 4; x++) begin
      o[x]   = w[x];
      o[4+x] = rotl(w[4+x], 1);
      o[8+x] = rotl(w[8+((x+2)%4)], 8);
    end
    return o;
  endfunction

  logic [11:0][31:0] pre_0, pre_1, chi_0, chi_1, rnd_w;

  assign rnd_w = rs;

  // Share 0 carries the inversion; cross terms are refreshed with one random bit each.
  always_comb begin
    pre_0 = lin_pre(in_0, rconst);
    pre_1 = lin_pre(in_1, 32'h0);
    chi_0 = '0;
    chi_1 = '0;
    for (int i = 0; i < 12; i++) begin
      int ia;
      int ib;
      ia = 4 * (((i / 4) + 1) % 3) + (i % 4);
      ib = 4 * (((i / 4) + 2) % 3) + (i % 4);
      chi_0[i] = pre_0[i] ^ (~pre_0[ia] & pre_0[ib]) ^ ((~pre_0[ia] & pre_1[ib]) ^ rnd_w[i]);
      chi_1[i] = pre_1[i] ^ ( pre_1[ia] & pre_1[ib]) ^ (( pre_1[ia] & pre_0[ib]) ^ rnd_w[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_0 <= '0;
      out_1 <= '0;
    end else begin
      out_0 <= lin_post(chi_0);
      out_1 <= lin_post(chi_1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/xoodoo_perm_driver_sca.sv
// Sequencer: twelve iterations of the masked round core with a valid/ready shell.
`default_nettype none

module xoodoo_perm_driver_sca
  import xoodoo_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [383:0] in_0,
  input  logic [383:0] in_1,
  input  logic         seed_we,
  input  logic [383:0] seed,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [383:0] out_0,
  output logic [383:0] out_1
);

  state_t       state;
  logic [3:0]   rnd;
  logic [383:0] rs;
  logic [383:0] core_in_0, core_in_1, core_out_0, core_out_1;
  logic [31:0]  rconst;
  logic         prng_load;

  assign prng_load = seed_we && (state == IDLE);

  xoodoo_prng_sca u_prng (
    .clk     (clk),
    .rst     (rst),
    .seed_we (prng_load),
    .seed    (seed),
    .rs      (rs)
  );

  // IDLE loads fresh shares every cycle so the accept edge itself computes round 0.
  always_comb begin
    core_in_0 = core_out_0;
    core_in_1 = core_out_1;
    rconst    = 32'h0;
    case (state)
      IDLE: begin
        core_in_0 = in_0;
        core_in_1 = in_1;
        rconst    = rc_lookup(4'd0);
      end
      BUSY:    rconst = rc_lookup(rnd);
      default: rconst = 32'h0;
    endcase
  end

  xoodoo_round_dom u_core (
    .clk    (clk),
    .rst    (rst),
    .in_0   (core_in_0),
    .in_1   (core_in_1),
    .rconst (rconst),
    .rs     (rs),
    .out_0  (core_out_0),
    .out_1  (core_out_1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rnd       <= 4'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_0     <= '0;
      out_1     <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          state    <= BUSY;
          rnd      <= 4'd1;
          in_ready <= 1'b0;
        end
        BUSY: if (rnd == LAST_RND) begin
          state <= CAPT;
          rnd   <= 4'd0;
        end else begin
          rnd <= rnd + 4'd1;
        end
        CAPT: begin
          out_0     <= core_out_0;
          out_1     <= core_out_1;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_xoodoo_perm_driver_sca.sv
// Directed bench for the masked Xoodoo sequencer against an unmasked reference permutation.
`default_nettype none

module tb_xoodoo_perm_driver_sca;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [383:0] in_0 = '0;
  logic [383:0] in_1 = '0;
  logic         seed_we = 1'b0;
  logic [383:0] seed = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [383:0] out_0;
  logic [383:0] out_1;

  int n_pass = 0;
  int n_checks = 0;

  localparam logic [31:0] RCT [12] = '{32'h058, 32'h038, 32'h3C0, 32'h0D0, 32'h120, 32'h014,
                                      32'h060, 32'h02C, 32'h380, 32'h0F0, 32'h1A0, 32'h012};

  xoodoo_perm_driver_sca dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_0      (in_0),
    .in_1      (in_1),
    .seed_we   (seed_we),
    .seed      (seed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_0     (out_0),
    .out_1     (out_1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [383:0] got, input logic [383:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 17);
    return t ^ (t << 5);
  endfunction

  // Plain, unmasked Xoodoo[12].
  function automatic logic [383:0] xoodoo12(input logic [383:0] s);
    logic [31:0] a [12];
    logic [31:0] b [12];
    logic [31:0] p [4];
    logic [31:0] e [4];
    logic [383:0] r;
    for (int i = 0; i < 12; i++) a[i] = s[32*i +: 32];
    for (int rn = 0; rn < 12; rn++) begin
      for (int x = 0; x < 4; x++) p[x] = a[x] ^ a[x+4] ^ a[x+8];
      for (int x = 0; x < 4; x++) e[x] = rl(p[(x+3)%4], 5) ^ rl(p[(x+3)%4], 14);
      for (int i = 0; i < 12; i++) a[i] = a[i] ^ e[i%4];
      for (int x = 0; x < 4; x++) begin
        b[x] = a[x]; b[4+x] = a[4+(x+3)%4]; b[8+x] = rl(a[8+x], 11);
      end
      b[0] = b[0] ^ RCT[rn];
      for (int i = 0; i < 12; i++)
        a[i] = b[i] ^ (~b[4*(((i/4)+1)%3) + i%4] & b[4*(((i/4)+2)%3) + i%4]);
      for (int x = 0; x < 4; x++) begin
        b[x] = a[x]; b[4+x] = rl(a[4+x], 1); b[8+x] = rl(a[8+(x+2)%4], 8);
      end
      for (int i = 0; i < 12; i++) a[i] = b[i];
    end
    for (int i = 0; i < 12; i++) r[32*i +: 32] = a[i];
    return r;
  endfunction

  function automatic logic [383:0] rand384();
    logic [383:0] v;
    for (int i = 0; i < 12; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic start_op(input logic [383:0] s0, input logic [383:0] s1);
    int w = 0;
    while (!in_ready && w < 40) begin tick(); w++; end
    check("in_ready_before_accept", 384'(in_ready), 384'(1));
    in_0 = s0; in_1 = s1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Waits for the result, holds it for 'stall' cycles, checks it, then completes the handshake.
  task automatic finish_op(input string tag, input logic [383:0] exp, input int stall, input int pre,
                           output logic [383:0] share0);
    int cnt;
    logic [383:0] h0, h1;
    cnt = pre;
    while (!out_valid && cnt < 40) begin tick(); cnt++; end
    check({tag, "_latency"}, 384'(cnt), 384'(12));
    check({tag, "_in_ready_done"}, 384'(in_ready), 384'(0));
    h0 = out_0; h1 = out_1;
    for (int k = 0; k < stall; k++) begin
      tick();
      check({tag, "_stall_valid"}, 384'(out_valid), 384'(1));
      check({tag, "_stall_in_ready"}, 384'(in_ready), 384'(0));
      check({tag, "_stall_out0"}, out_0, h0);
      check({tag, "_stall_out1"}, out_1, h1);
    end
    check({tag, "_result"}, out_0 ^ out_1, exp);
    share0 = out_0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_in_ready_after"}, 384'(in_ready), 384'(1));
    check({tag, "_valid_after"}, 384'(out_valid), 384'(0));
  endtask

  initial begin
    logic [383:0] x, r, exp_rs, sd, a0, b0, dummy;
    logic [31:0] wv;

    repeat (2) tick();
    rst = 1'b0;
    check("rst_in_ready", 384'(in_ready), 384'(1));
    check("rst_out_valid", 384'(out_valid), 384'(0));
    check("rst_out_0", out_0, '0);
    check("rst_out_1", out_1, '0);
    for (int i = 0; i < 12; i++) exp_rs[32*i +: 32] = 32'h9E3779B9 ^ 32'(i);
    check("rst_prng", dut.u_prng.rs, exp_rs);

    // Zero state, no stall.
    start_op('0, '0);
    finish_op("zero", xoodoo12('0), 0, 0, dummy);

    // Same secret, two different sharings.
    x = rand384();
    start_op(x, '0);
    finish_op("share_a", xoodoo12(x), 0, 0, a0);
    r = rand384();
    start_op(x ^ r, r);
    finish_op("share_b", xoodoo12(x), 5, 0, b0);
    check("share_out0_differs", 384'(a0 != b0), 384'(1));

    // Reset while BUSY with rnd=5, then a fresh run.
    start_op(x ^ r, r);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_in_ready", 384'(in_ready), 384'(1));
    check("midrst_out_valid", 384'(out_valid), 384'(0));
    check("midrst_out_0", out_0, '0);
    check("midrst_out_1", out_1, '0);
    x = rand384(); r = rand384();
    start_op(x ^ r, r);
    finish_op("post_rst", xoodoo12(x), 1, 0, dummy);

    // All-zero seed collapses to ones; seed_we in BUSY is ignored.
    seed = '0; seed_we = 1'b1;
    tick();
    seed_we = 1'b0;
    check("seed_zero", dut.u_prng.rs, {12{32'h00000001}});
    x = rand384(); r = rand384();
    start_op(x ^ r, r);
    seed = rand384(); seed_we = 1'b1;
    repeat (3) tick();
    seed_we = 1'b0;
    wv = 32'h1;
    repeat (4) wv = xs(wv);
    check("seed_busy_ignored", dut.u_prng.rs, {12{wv}});
    finish_op("seed_busy", xoodoo12(x), 0, 3, dummy);

    // Reseed and accept in the same cycle, with one zero word in the seed.
    sd = rand384();
    sd[32*5 +: 32] = 32'h0;
    exp_rs = sd;
    exp_rs[32*5 +: 32] = 32'h1;
    x = rand384(); r = rand384();
    seed = sd; seed_we = 1'b1; in_0 = x ^ r; in_1 = r; in_valid = 1'b1;
    tick();
    seed_we = 1'b0; in_valid = 1'b0;
    check("seed_with_accept", dut.u_prng.rs, exp_rs);
    finish_op("seed_accept", xoodoo12(x), 0, 0, dummy);

    // Random shares, seeds and stalls.
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        seed = rand384(); seed_we = 1'b1;
        tick();
        seed_we = 1'b0;
      end
      x = rand384(); r = rand384();
      start_op(x ^ r, r);
      finish_op("regr", xoodoo12(x), int'($urandom_range(0, 3)), 0, dummy);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
